// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit processor: bus/opcode/PC widths, halt opcode
// and the one-hot T-state encodings.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned PC_W   = 4;
    localparam int unsigned NUM_T  = 6;

    localparam logic [OPC_W-1:0] HLT_OPCODE = 4'hF;

    localparam logic [NUM_T-1:0] T1 = 6'b000001;
    localparam logic [NUM_T-1:0] T2 = 6'b000010;
    localparam logic [NUM_T-1:0] T3 = 6'b000100;
    localparam logic [NUM_T-1:0] T4 = 6'b001000;
    localparam logic [NUM_T-1:0] T5 = 6'b010000;
    localparam logic [NUM_T-1:0] T6 = 6'b100000;

endpackage

// File: rtl/t_state_ring.sv
// One-hot T-state ring: rotates one position per advance, can restart at bit0,
// and can be held in place.
module t_state_ring #(
    parameter int unsigned NUM_T = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             adv_i,
    input  logic             restart_i,
    input  logic             hold_i,
    output logic [NUM_T-1:0] state_o
);

    localparam logic [NUM_T-1:0] First = NUM_T'(1);

    logic [NUM_T-1:0] state_d, state_q;

    always_comb begin
        state_d = state_q;
        if (adv_i && !hold_i) begin
            if (restart_i) begin
                state_d = First;
            end else begin
                state_d = {state_q[NUM_T-2:0], state_q[NUM_T-1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= First;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction-fetch and timing sequencer: PC, IR, halt flag and fetch strobes
// driven from a six-state one-hot T-state ring.
module instr_fetch_seq
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [DATA_W-1:0] ir_data,
    input  logic              end_early,
    input  logic              jump_en,
    input  logic [PC_W-1:0]   jump_addr,
    output logic [NUM_T-1:0]  t_state,
    output logic [OPC_W-1:0]  opcode,
    output logic [DATA_W-OPC_W-1:0] operand,
    output logic [PC_W-1:0]   pc,
    output logic              mar_load,
    output logic              pc_inc,
    output logic              ir_load,
    output logic              instr_done,
    output logic              halted
);

    logic [PC_W-1:0]   pc_d, pc_q;
    logic [DATA_W-1:0] ir_d, ir_q;
    logic              halted_d, halted_q;

    logic adv, t1, t2, t3, t4, t5, t6;
    logic hlt_now, restart, jump_now;

    // rst_n in adv keeps every strobe low while reset is held
    assign adv = run & ~halted_q & rst_n;

    assign t1 = t_state[0];
    assign t2 = t_state[1];
    assign t3 = t_state[2];
    assign t4 = t_state[3];
    assign t5 = t_state[4];
    assign t6 = t_state[5];

    assign opcode  = ir_q[DATA_W-1:DATA_W-OPC_W];
    assign operand = ir_q[DATA_W-OPC_W-1:0];
    assign pc      = pc_q;
    assign halted  = halted_q;

    // HLT wins over end_early and jump_en in the same T4 cycle
    assign hlt_now  = adv & t4 & (opcode == HLT_OPCODE);
    assign restart  = (t4 | t5) & end_early;
    assign jump_now = adv & (t4 | t5 | t6) & jump_en & ~hlt_now;

    assign mar_load   = t1 & adv;
    assign pc_inc     = t2 & adv;
    assign ir_load    = t3 & adv;
    assign instr_done = adv & ~hlt_now & (t6 | ((t4 | t5) & end_early));

    t_state_ring #(
        .NUM_T(NUM_T)
    ) u_ring (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .adv_i    (adv),
        .restart_i(restart),
        .hold_i   (hlt_now),
        .state_o  (t_state)
    );

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q | hlt_now;
        if (pc_inc) begin
            pc_d = pc_q + PC_W'(1);
        end else if (jump_now) begin
            pc_d = jump_addr;
        end
        if (ir_load) begin
            ir_d = ir_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: per-test stimulus and expected-output
// queues, one entry per clock cycle, compared mid-cycle on the falling edge.
module tb_instr_fetch_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] ir_data = 8'h00;
    logic       end_early = 1'b0;
    logic       jump_en = 1'b0;
    logic [3:0] jump_addr = 4'h0;

    logic [5:0] t_state;
    logic [3:0] opcode, operand, pc;
    logic       mar_load, pc_inc, ir_load, instr_done, halted;

    instr_fetch_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .ir_data   (ir_data),
        .end_early (end_early),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .t_state   (t_state),
        .opcode    (opcode),
        .operand   (operand),
        .pc        (pc),
        .mar_load  (mar_load),
        .pc_inc    (pc_inc),
        .ir_load   (ir_load),
        .instr_done(instr_done),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef logic [22:0] obs_t;  // {t_state, pc, opcode, operand, mar, inc, irl, done, hlt}
    typedef logic [14:0] stim_t; // {run, end_early, jump_en, jump_addr, ir_data}

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] MAR  = 5'b10000;
    localparam logic [4:0] INC  = 5'b01000;
    localparam logic [4:0] IRL  = 5'b00100;
    localparam logic [4:0] DONE = 5'b00010;
    localparam logic [4:0] HLT  = 5'b00001;

    int    checks = 0;
    int    errors = 0;
    obs_t  exp_q[$];
    stim_t stim_q[$];
    obs_t  obs, e;
    stim_t s;

    assign obs = {t_state, pc, opcode, operand, mar_load, pc_inc, ir_load, instr_done, halted};

    function automatic obs_t mk(logic [5:0] t, logic [3:0] p, logic [7:0] ir, logic [4:0] st);
        return {t, p, ir, st};
    endfunction

    function automatic stim_t sv(logic r, logic ee, logic je, logic [3:0] ja, logic [7:0] d);
        return {r, ee, je, ja, d};
    endfunction

    // Leaves the bench 1 time unit after a rising edge with the DUT in T1, pc=0.
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        run = 1'b1; end_early = 1'b0; jump_en = 1'b0; jump_addr = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; run = 1'b1; end_early = 1'b1; jump_en = 1'b1;
        #2;
        checks++;
        if (obs !== mk(6'h01, 4'h0, 8'h00, NONE)) begin
            errors++;
            $display("FAIL reset_hold got %h exp %h", obs, mk(6'h01, 4'h0, 8'h00, NONE));
        end
        @(posedge clk); #1;
        rst_n = 1'b1; end_early = 1'b0; jump_en = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== mk(6'h01, 4'h0, 8'h00, MAR)) begin
            errors++;
            $display("FAIL reset_release got %h exp %h", obs, mk(6'h01, 4'h0, 8'h00, MAR));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        do_reset();
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h3A)); exp_q.push_back(mk(6'h01, 4'h0, 8'h00, MAR));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h3A)); exp_q.push_back(mk(6'h02, 4'h0, 8'h00, INC));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h3A)); exp_q.push_back(mk(6'h04, 4'h1, 8'h00, IRL));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h3A)); exp_q.push_back(mk(6'h08, 4'h1, 8'h3A, NONE));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h3A)); exp_q.push_back(mk(6'h10, 4'h1, 8'h3A, NONE));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h3A)); exp_q.push_back(mk(6'h20, 4'h1, 8'h3A, DONE));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h3A)); exp_q.push_back(mk(6'h01, 4'h1, 8'h3A, MAR));
        for (int n = 0; stim_q.size() != 0; n++) begin
            s = stim_q.pop_front();
            {run, end_early, jump_en, jump_addr, ir_data} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL fetch cyc %0d got %h exp %h", n, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_end_early();
        do_reset();
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h25)); exp_q.push_back(mk(6'h01, 4'h0, 8'h00, MAR));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h25)); exp_q.push_back(mk(6'h02, 4'h0, 8'h00, INC));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h25)); exp_q.push_back(mk(6'h04, 4'h1, 8'h00, IRL));
        stim_q.push_back(sv(1, 1, 0, 4'h0, 8'h25)); exp_q.push_back(mk(6'h08, 4'h1, 8'h25, DONE));
        // end_early held through the next fetch must be ignored
        stim_q.push_back(sv(1, 1, 0, 4'h0, 8'h25)); exp_q.push_back(mk(6'h01, 4'h1, 8'h25, MAR));
        stim_q.push_back(sv(1, 1, 0, 4'h0, 8'h25)); exp_q.push_back(mk(6'h02, 4'h1, 8'h25, INC));
        stim_q.push_back(sv(1, 1, 0, 4'h0, 8'h25)); exp_q.push_back(mk(6'h04, 4'h2, 8'h25, IRL));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h25)); exp_q.push_back(mk(6'h08, 4'h2, 8'h25, NONE));
        stim_q.push_back(sv(1, 1, 0, 4'h0, 8'h25)); exp_q.push_back(mk(6'h10, 4'h2, 8'h25, DONE));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h25)); exp_q.push_back(mk(6'h01, 4'h2, 8'h25, MAR));
        for (int n = 0; stim_q.size() != 0; n++) begin
            s = stim_q.pop_front();
            {run, end_early, jump_en, jump_addr, ir_data} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL end_early cyc %0d got %h exp %h", n, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump();
        do_reset();
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h10)); exp_q.push_back(mk(6'h01, 4'h0, 8'h00, MAR));
        // jump in T2 is ignored, increment wins
        stim_q.push_back(sv(1, 0, 1, 4'hC, 8'h10)); exp_q.push_back(mk(6'h02, 4'h0, 8'h00, INC));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h10)); exp_q.push_back(mk(6'h04, 4'h1, 8'h00, IRL));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h10)); exp_q.push_back(mk(6'h08, 4'h1, 8'h10, NONE));
        stim_q.push_back(sv(1, 0, 1, 4'hC, 8'h10)); exp_q.push_back(mk(6'h10, 4'h1, 8'h10, NONE));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h10)); exp_q.push_back(mk(6'h20, 4'hC, 8'h10, DONE));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h10)); exp_q.push_back(mk(6'h01, 4'hC, 8'h10, MAR));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h10)); exp_q.push_back(mk(6'h02, 4'hC, 8'h10, INC));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h10)); exp_q.push_back(mk(6'h04, 4'hD, 8'h10, IRL));
        stim_q.push_back(sv(1, 0, 1, 4'hF, 8'h10)); exp_q.push_back(mk(6'h08, 4'hD, 8'h10, NONE));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h10)); exp_q.push_back(mk(6'h10, 4'hF, 8'h10, NONE));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h10)); exp_q.push_back(mk(6'h20, 4'hF, 8'h10, DONE));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h10)); exp_q.push_back(mk(6'h01, 4'hF, 8'h10, MAR));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h10)); exp_q.push_back(mk(6'h02, 4'hF, 8'h10, INC));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h10)); exp_q.push_back(mk(6'h04, 4'h0, 8'h10, IRL));
        for (int n = 0; stim_q.size() != 0; n++) begin
            s = stim_q.pop_front();
            {run, end_early, jump_en, jump_addr, ir_data} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL jump cyc %0d got %h exp %h", n, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        do_reset();
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'hF0)); exp_q.push_back(mk(6'h01, 4'h0, 8'h00, MAR));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'hF0)); exp_q.push_back(mk(6'h02, 4'h0, 8'h00, INC));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'hF0)); exp_q.push_back(mk(6'h04, 4'h1, 8'h00, IRL));
        stim_q.push_back(sv(1, 1, 1, 4'h7, 8'hF0)); exp_q.push_back(mk(6'h08, 4'h1, 8'hF0, NONE));
        stim_q.push_back(sv(1, 1, 1, 4'h7, 8'hF0)); exp_q.push_back(mk(6'h08, 4'h1, 8'hF0, HLT));
        stim_q.push_back(sv(0, 0, 0, 4'h7, 8'hF0)); exp_q.push_back(mk(6'h08, 4'h1, 8'hF0, HLT));
        stim_q.push_back(sv(1, 1, 1, 4'h7, 8'hF0)); exp_q.push_back(mk(6'h08, 4'h1, 8'hF0, HLT));
        stim_q.push_back(sv(1, 0, 0, 4'h7, 8'hF0)); exp_q.push_back(mk(6'h08, 4'h1, 8'hF0, HLT));
        for (int n = 0; stim_q.size() != 0; n++) begin
            s = stim_q.pop_front();
            {run, end_early, jump_en, jump_addr, ir_data} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL halt cyc %0d got %h exp %h", n, obs, e);
            end
            @(posedge clk); #1;
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (obs !== mk(6'h01, 4'h0, 8'h00, MAR)) begin
            errors++;
            $display("FAIL halt_clear got %h exp %h", obs, mk(6'h01, 4'h0, 8'h00, MAR));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_run_freeze();
        do_reset();
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h5C)); exp_q.push_back(mk(6'h01, 4'h0, 8'h00, MAR));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h5C)); exp_q.push_back(mk(6'h02, 4'h0, 8'h00, INC));
        stim_q.push_back(sv(0, 0, 0, 4'h0, 8'h5C)); exp_q.push_back(mk(6'h04, 4'h1, 8'h00, NONE));
        stim_q.push_back(sv(0, 1, 1, 4'h9, 8'h6D)); exp_q.push_back(mk(6'h04, 4'h1, 8'h00, NONE));
        stim_q.push_back(sv(0, 0, 0, 4'h0, 8'h6D)); exp_q.push_back(mk(6'h04, 4'h1, 8'h00, NONE));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h6D)); exp_q.push_back(mk(6'h04, 4'h1, 8'h00, IRL));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h77)); exp_q.push_back(mk(6'h08, 4'h1, 8'h6D, NONE));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h77)); exp_q.push_back(mk(6'h10, 4'h1, 8'h6D, NONE));
        for (int n = 0; stim_q.size() != 0; n++) begin
            s = stim_q.pop_front();
            {run, end_early, jump_en, jump_addr, ir_data} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL run_freeze cyc %0d got %h exp %h", n, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h3A)); exp_q.push_back(mk(6'h01, 4'h0, 8'h00, MAR));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h3A)); exp_q.push_back(mk(6'h02, 4'h0, 8'h00, INC));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h3A)); exp_q.push_back(mk(6'h04, 4'h1, 8'h00, IRL));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h3A)); exp_q.push_back(mk(6'h08, 4'h1, 8'h3A, NONE));
        stim_q.push_back(sv(1, 0, 0, 4'h0, 8'h3A)); exp_q.push_back(mk(6'h10, 4'h1, 8'h3A, NONE));
        for (int n = 0; stim_q.size() != 0; n++) begin
            s = stim_q.pop_front();
            {run, end_early, jump_en, jump_addr, ir_data} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL async_reset cyc %0d got %h exp %h", n, obs, e);
            end
            if (stim_q.size() != 0) begin
                @(posedge clk); #1;
            end
        end
        // Still mid-T5, well clear of the next rising edge
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== mk(6'h01, 4'h0, 8'h00, NONE)) begin
            errors++;
            $display("FAIL async_reset_now got %h exp %h", obs, mk(6'h01, 4'h0, 8'h00, NONE));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== mk(6'h01, 4'h0, 8'h00, MAR)) begin
            errors++;
            $display("FAIL async_restart_t1 got %h exp %h", obs, mk(6'h01, 4'h0, 8'h00, MAR));
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs !== mk(6'h02, 4'h0, 8'h00, INC)) begin
            errors++;
            $display("FAIL async_restart_t2 got %h exp %h", obs, mk(6'h02, 4'h0, 8'h00, INC));
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_end_early();
        test_jump();
        test_halt();
        test_run_freeze();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
